// File: rtl/tcm_pkg.sv
// rtl/tcm_pkg.sv - shared types and constants for the two-port TCM arbiter
package tcm_pkg;

   localparam int TCM_NPORTS = 2;

   typedef enum logic {
      IFU = 1'b0,
      LSU = 1'b1
   } tcm_port_e;

   typedef struct packed {
      logic      valid;
      tcm_port_e port;
      logic      we;
      logic      err;
   } tcm_rsp_t;

endpackage

// File: rtl/tcm_rr_arb.sv
// rtl/tcm_rr_arb.sv - two-input round-robin / fixed-priority grant generator
module tcm_rr_arb
   import tcm_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [TCM_NPORTS-1:0] req_i,
   output logic [TCM_NPORTS-1:0] gnt_o
);

   tcm_port_e             last_d, last_q;
   logic                  contended;
   logic [TCM_NPORTS-1:0] gnt;

   always_comb begin
      contended = &req_i;
      gnt       = req_i;
      if (contended) begin
         if (FIXED_PRIO) begin
            gnt = 2'b10;
         end else begin
            gnt = (last_q == LSU) ? 2'b01 : 2'b10;
         end
      end
      gnt_o = rst_ni ? gnt : '0;

      // Only contention moves the pointer, so a lone requester never steals the next turn.
      last_d = last_q;
      if (contended && rst_ni) begin
         last_d = gnt[1] ? LSU : IFU;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         last_q <= LSU;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/tcm_arbiter.sv
// rtl/tcm_arbiter.sv - shares one single-port TCM between fetch (port 0) and load/store (port 1)
module tcm_arbiter
   import tcm_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH          = 8192,
   parameter int ADDR_WIDTH     = $clog2(DEPTH * DATA_WIDTH / 8),
   parameter int REQ_ADDR_WIDTH = 32,
   parameter bit FIXED_PRIO     = 1'b0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      req_i    [TCM_NPORTS],
   input  logic [REQ_ADDR_WIDTH-1:0] addr_i   [TCM_NPORTS],
   input  logic                      we_i     [TCM_NPORTS],
   input  logic [DATA_WIDTH/8-1:0]   be_i     [TCM_NPORTS],
   input  logic [DATA_WIDTH-1:0]     wdata_i  [TCM_NPORTS],
   output logic                      gnt_o    [TCM_NPORTS],
   output logic                      rvalid_o [TCM_NPORTS],
   output logic [DATA_WIDTH-1:0]     rdata_o  [TCM_NPORTS],
   output logic                      err_o    [TCM_NPORTS],
   output logic                      tcm_en_o,
   output logic [ADDR_WIDTH-1:0]     tcm_addr_o,
   output logic                      tcm_we_o,
   output logic [DATA_WIDTH/8-1:0]   tcm_be_o,
   output logic [DATA_WIDTH-1:0]     tcm_wdata_o,
   input  logic [DATA_WIDTH-1:0]     tcm_rdata_i
);

   localparam int                      BE_WIDTH  = DATA_WIDTH / 8;
   localparam logic [REQ_ADDR_WIDTH:0] TCM_BYTES = (REQ_ADDR_WIDTH + 1)'(DEPTH * BE_WIDTH);

   logic [TCM_NPORTS-1:0]     req_vec, gnt_vec;
   logic                      any_gnt, win, in_range, rsp_live;
   logic [REQ_ADDR_WIDTH-1:0] sel_addr;
   tcm_rsp_t                  rsp_d, rsp_q;

   assign req_vec = {req_i[1], req_i[0]};

   tcm_rr_arb #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .req_i (req_vec),
      .gnt_o (gnt_vec)
   );

   always_comb begin
      any_gnt  = |gnt_vec;
      win      = gnt_vec[1];
      sel_addr = addr_i[win];
      in_range = {1'b0, sel_addr} < TCM_BYTES;

      tcm_en_o    = 1'b0;
      tcm_addr_o  = '0;
      tcm_we_o    = 1'b0;
      tcm_be_o    = '0;
      tcm_wdata_o = '0;
      if (any_gnt) begin
         // Out-of-range accesses still get granted but never touch the array.
         tcm_en_o    = in_range;
         tcm_addr_o  = sel_addr[ADDR_WIDTH-1:0];
         tcm_we_o    = we_i[win];
         tcm_be_o    = be_i[win];
         tcm_wdata_o = wdata_i[win];
      end

      rsp_d       = '0;
      rsp_d.valid = any_gnt;
      rsp_d.port  = win ? LSU : IFU;
      rsp_d.we    = we_i[win];
      rsp_d.err   = !in_range;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   // Gating with rst_ni drops a response that was in flight when reset hit.
   assign rsp_live = rst_ni && rsp_q.valid;

   always_comb begin
      for (int p = 0; p < TCM_NPORTS; p++) begin
         gnt_o[p]    = gnt_vec[p];
         rvalid_o[p] = rsp_live && (logic'(rsp_q.port) == p[0]);
         err_o[p]    = rsp_live && (logic'(rsp_q.port) == p[0]) && rsp_q.err;
         rdata_o[p]  = (rsp_live && (logic'(rsp_q.port) == p[0]) && !rsp_q.we && !rsp_q.err)
                       ? tcm_rdata_i : '0;
      end
   end

endmodule
